mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Runs a request/valid handshake on each side, a fixed-latency access sequencer on the memory side, and produces per-requester stall signals for the hazards unit.
- Data accesses normally win arbitration. A starvation guard can be compiled in to protect fetch.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/arb_latency_counter.sv | 31 +++
 rtl/mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package cpu_mem_pkg;

  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_latency_counter.sv
// Loadable down-counter with a zero flag, used to time the memory read latency.
module arb_latency_counter
  import cpu_mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int CW      = $clog2(LATENCY + 1)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_loadValue,
  input  logic          i_decrement,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  // Load has priority over decrement; the count never wraps below zero
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_decrement && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// data load/store. Data normally wins; defining ARB_STARVE_GUARD_EN compiles
// in a starvation counter that forces a fetch grant after STARVELIMIT
// consecutive fetch losses.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int LATENCY          = DEFAULT_LATENCY,
  parameter int STARVELIMIT      = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        fetchReq,
  input  logic [WIDTH-1:0]            fetchAddress,
  input  logic                        fetchFlush,
  output logic                        fetchValid,
  output logic [INSTRUCTIONWIDTH-1:0] fetchInstruction,
  output logic                        fetchStall,
  input  logic                        dataReq,
  input  logic                        dataWrite,
  input  logic [WIDTH-1:0]            dataAddress,
  input  logic [WIDTH-1:0]            dataWriteData,
  output logic                        dataValid,
  output logic [WIDTH-1:0]            dataReadData,
  output logic                        dataStall,
  output logic                        memReq,
  output logic                        memWrite,
  output logic [WIDTH-1:0]            memAddress,
  output logic [WIDTH-1:0]            memWriteData,
  input  logic [INSTRUCTIONWIDTH-1:0] memReadData
);

  localparam int CW = $clog2(LATENCY + 1);

  // A zero latency or zero starvation limit has no meaningful schedule
  if (LATENCY < 1 || STARVELIMIT < 1) begin : g_param_check
    $error("mem_port_arbiter: LATENCY and STARVELIMIT must both be >= 1");
  end

  arb_state_t r_state, w_stateNext;
  arb_owner_t r_owner, w_ownerNext, w_grantOwner;

  logic                        r_write, w_writeNext;
  logic                        r_discard, w_discardNext;
  logic                        w_flushHit, w_discard;
  logic                        r_memReq, w_memReqNext;
  logic                        r_memWrite, w_memWriteNext;
  logic [WIDTH-1:0]            r_memAddress, w_memAddressNext;
  logic [WIDTH-1:0]            r_memWriteData, w_memWriteDataNext;
  logic                        r_fetchValid, w_fetchValidNext;
  logic                        r_dataValid, w_dataValidNext;
  logic [INSTRUCTIONWIDTH-1:0] r_fetchInstruction, w_fetchInstructionNext;
  logic [WIDTH-1:0]            r_dataReadData, w_dataReadDataNext;

  logic w_anyReq, w_grant, w_forceFetch;
  logic w_cntLoad, w_cntDec, w_cntZero;

  assign w_anyReq     = fetchReq | dataReq;
  assign w_grant      = (r_state == IDLE) && w_anyReq;
  assign w_grantOwner = (dataReq && !w_forceFetch) ? DATA : FETCH;

  // A flush only matters while a fetch is actually occupying the memory
  assign w_flushHit = fetchFlush && (r_owner == FETCH) &&
                      ((r_state == ISSUE) || (r_state == WAIT));
  assign w_discard  = r_discard | w_flushHit;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVELIMIT + 1);

  logic [SCW-1:0] r_starveCount;

  assign w_forceFetch = fetchReq && (r_starveCount == SCW'(STARVELIMIT));

  // Count consecutive grants lost by a waiting fetch; a fetch grant clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starveCount <= '0;
    end else if (w_grant) begin
      if (w_grantOwner == FETCH) begin
        r_starveCount <= '0;
      end else if (fetchReq && (r_starveCount != SCW'(STARVELIMIT))) begin
        r_starveCount <= r_starveCount + 1'b1;
      end
    end
  end
`else
  assign w_forceFetch = 1'b0;
`endif

  arb_latency_counter #(
    .LATENCY (LATENCY),
    .CW      (CW)
  ) u_latency_counter (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_load      (w_cntLoad),
    .i_loadValue (CW'(LATENCY - 1)),
    .i_decrement (w_cntDec),
    .o_zero      (w_cntZero)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode: writes skip WAIT, reads wait out the latency counter
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_stateNext = ISSUE;
      ISSUE:   w_stateNext = r_write ? RESPOND : WAIT;
      WAIT:    if (w_cntZero) w_stateNext = RESPOND;
      RESPOND: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Output decode: next values for every registered output and control flag
  always_comb begin
    w_ownerNext            = r_owner;
    w_writeNext            = r_write;
    w_discardNext          = w_discard;
    w_memReqNext           = 1'b0;
    w_memWriteNext         = 1'b0;
    w_memAddressNext       = r_memAddress;
    w_memWriteDataNext     = r_memWriteData;
    w_fetchValidNext       = 1'b0;
    w_dataValidNext        = 1'b0;
    w_fetchInstructionNext = r_fetchInstruction;
    w_dataReadDataNext     = r_dataReadData;
    w_cntLoad              = 1'b0;
    w_cntDec               = 1'b0;
    case (r_state)
      IDLE: begin
        w_discardNext = 1'b0;
        if (w_anyReq) begin
          w_ownerNext  = w_grantOwner;
          w_memReqNext = 1'b1;
          if (w_grantOwner == DATA) begin
            w_writeNext        = dataWrite;
            w_memWriteNext     = dataWrite;
            w_memAddressNext   = dataAddress;
            w_memWriteDataNext = dataWriteData;
          end else begin
            w_writeNext      = 1'b0;
            w_memAddressNext = fetchAddress;
          end
        end
      end
      ISSUE: begin
        // Only data accesses can be stores; memory commits them this cycle
        if (r_write) begin
          w_dataValidNext = 1'b1;
        end else begin
          w_cntLoad = 1'b1;
        end
      end
      WAIT: begin
        if (w_cntZero) begin
          if (r_owner == DATA) begin
            w_dataReadDataNext = memReadData[WIDTH-1:0];
            w_dataValidNext    = 1'b1;
          end else if (!w_discard) begin
            w_fetchInstructionNext = memReadData;
            w_fetchValidNext       = 1'b1;
          end
        end else begin
          w_cntDec = 1'b1;
        end
      end
      RESPOND: begin
        w_discardNext = 1'b0;
      end
      default: begin
        w_discardNext = 1'b0;
      end
    endcase
  end

  // Registered outputs, ownership and discard flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner            <= FETCH;
      r_write            <= 1'b0;
      r_discard          <= 1'b0;
      r_memReq           <= 1'b0;
      r_memWrite         <= 1'b0;
      r_memAddress       <= '0;
      r_memWriteData     <= '0;
      r_fetchValid       <= 1'b0;
      r_dataValid        <= 1'b0;
      r_fetchInstruction <= '0;
      r_dataReadData     <= '0;
    end else begin
      r_owner            <= w_ownerNext;
      r_write            <= w_writeNext;
      r_discard          <= w_discardNext;
      r_memReq           <= w_memReqNext;
      r_memWrite         <= w_memWriteNext;
      r_memAddress       <= w_memAddressNext;
      r_memWriteData     <= w_memWriteDataNext;
      r_fetchValid       <= w_fetchValidNext;
      r_dataValid        <= w_dataValidNext;
      r_fetchInstruction <= w_fetchInstructionNext;
      r_dataReadData     <= w_dataReadDataNext;
    end
  end

  assign memReq           = r_memReq;
  assign memWrite         = r_memWrite;
  assign memAddress       = r_memAddress;
  assign memWriteData     = r_memWriteData;
  assign fetchValid       = r_fetchValid;
  assign dataValid        = r_dataValid;
  assign fetchInstruction = r_fetchInstruction;
  assign dataReadData     = r_dataReadData;

  // Stalls are combinational so the hazards unit sees them in the request cycle
  assign fetchStall = fetchReq && !r_fetchValid;
  assign dataStall  = dataReq && !r_dataValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with LATENCY=2.
module tb_mem_port_arbiter;

  localparam int WIDTH = 16;
  localparam int IW    = 24;
  localparam int LAT   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetchReq, fetchFlush, fetchValid, fetchStall;
  logic [WIDTH-1:0] fetchAddress;
  logic [IW-1:0] fetchInstruction;
  logic          dataReq, dataWrite, dataValid, dataStall;
  logic [WIDTH-1:0] dataAddress, dataWriteData, dataReadData;
  logic          memReq, memWrite;
  logic [WIDTH-1:0] memAddress, memWriteData;
  logic [IW-1:0] memReadData;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  // Memory model: read data is only driven in the cycle LAT cycles after memReq
  logic [1:0]    rd_pipe  = 2'b00;
  logic [IW-1:0] tb_rdata = '0;
  always @(posedge clock) rd_pipe <= {rd_pipe[0], memReq & ~memWrite};
  assign memReadData = rd_pipe[1] ? tb_rdata : '0;

  mem_port_arbiter #(
    .WIDTH(WIDTH), .INSTRUCTIONWIDTH(IW), .LATENCY(LAT), .STARVELIMIT(3)
  ) dut (
    .clock(clock), .reset(reset),
    .fetchReq(fetchReq), .fetchAddress(fetchAddress), .fetchFlush(fetchFlush),
    .fetchValid(fetchValid), .fetchInstruction(fetchInstruction), .fetchStall(fetchStall),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress),
    .dataWriteData(dataWriteData), .dataValid(dataValid), .dataReadData(dataReadData),
    .dataStall(dataStall),
    .memReq(memReq), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if ({memReq, memWrite} !== 2'b00) $display("FAIL reset_memctl got %b want 00", {memReq, memWrite}); else passed++;
    total++; if ({memAddress, memWriteData} !== 32'h0) $display("FAIL reset_memaddr_wdata got %h want 0", {memAddress, memWriteData}); else passed++;
    total++; if ({fetchValid, dataValid} !== 2'b00) $display("FAIL reset_valids got %b want 00", {fetchValid, dataValid}); else passed++;
    total++; if ({fetchInstruction, dataReadData} !== 40'h0) $display("FAIL reset_rdata got %h want 0", {fetchInstruction, dataReadData}); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    fetchReq = 1'b1; fetchAddress = 16'h0004; tb_rdata = 24'hABCDEF;
    #1;
    total++; if (fetchStall !== 1'b1) $display("FAIL fetch_stall_c0 got %b want 1", fetchStall); else passed++;
    total++; if (memReq !== 1'b0) $display("FAIL fetch_memreq_c0 got %b want 0", memReq); else passed++;
    tick();
    total++; if ({memReq, memWrite, memAddress} !== {2'b10, 16'h0004}) $display("FAIL fetch_issue_c1 got %h want %h", {memReq, memWrite, memAddress}, {2'b10, 16'h0004}); else passed++;
    for (int c = 2; c <= 3; c++) begin
      tick();
      total++; if ({fetchStall, fetchValid, memReq} !== 3'b100) $display("FAIL fetch_wait_c%0d got %b want 100", c, {fetchStall, fetchValid, memReq}); else passed++;
    end
    tick();
    total++; if ({fetchValid, fetchStall} !== 2'b10) $display("FAIL fetch_valid_c4 got %b want 10", {fetchValid, fetchStall}); else passed++;
    total++; if (fetchInstruction !== 24'hABCDEF) $display("FAIL fetch_instr_c4 got %h want abcdef", fetchInstruction); else passed++;
    tick();
    fetchReq = 1'b0;
    total++; if (fetchValid !== 1'b0) $display("FAIL fetch_valid_c5 got %b want 0", fetchValid); else passed++;
    tick();
    total++; if (memReq !== 1'b0) $display("FAIL fetch_no_regrant_c6 got %b want 0", memReq); else passed++;
  endtask

  task automatic test_simultaneous();
    fetchReq = 1'b1; fetchAddress = 16'h0020;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 16'h0030; tb_rdata = 24'h11BEEF;
    tick();
    total++; if ({memReq, memAddress} !== {1'b1, 16'h0030}) $display("FAIL simul_data_first_c1 got %h want %h", {memReq, memAddress}, {1'b1, 16'h0030}); else passed++;
    tick(); tick(); tick();
    total++; if ({dataValid, fetchValid, fetchStall, dataStall} !== 4'b1010) $display("FAIL simul_flags_c4 got %b want 1010", {dataValid, fetchValid, fetchStall, dataStall}); else passed++;
    total++; if (dataReadData !== 16'hBEEF) $display("FAIL simul_drdata_c4 got %h want beef", dataReadData); else passed++;
    tick();
    dataReq = 1'b0; tb_rdata = 24'h654321;
    total++; if (memReq !== 1'b0) $display("FAIL simul_memreq_c5 got %b want 0", memReq); else passed++;
    tick();
    total++; if ({memReq, memAddress} !== {1'b1, 16'h0020}) $display("FAIL simul_fetch_issue_c6 got %h want %h", {memReq, memAddress}, {1'b1, 16'h0020}); else passed++;
    tick(); tick();
    total++; if (fetchValid !== 1'b0) $display("FAIL simul_fetch_early_c8 got %b want 0", fetchValid); else passed++;
    tick();
    total++; if ({fetchValid, fetchInstruction} !== {1'b1, 24'h654321}) $display("FAIL simul_fetch_valid_c9 got %h want %h", {fetchValid, fetchInstruction}, {1'b1, 24'h654321}); else passed++;
    tick();
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_store();
    dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 16'h0010; dataWriteData = 16'h1234;
    #1;
    total++; if (dataStall !== 1'b1) $display("FAIL store_stall_c0 got %b want 1", dataStall); else passed++;
    tick();
    total++; if ({memReq, memWrite, memAddress, memWriteData} !== {2'b11, 16'h0010, 16'h1234}) $display("FAIL store_issue_c1 got %h want %h", {memReq, memWrite, memAddress, memWriteData}, {2'b11, 16'h0010, 16'h1234}); else passed++;
    tick();
    total++; if ({dataValid, memReq, memWrite, dataStall} !== 4'b1000) $display("FAIL store_valid_c2 got %b want 1000", {dataValid, memReq, memWrite, dataStall}); else passed++;
    total++; if (dataReadData !== 16'hBEEF) $display("FAIL store_drdata_kept got %h want beef", dataReadData); else passed++;
    tick();
    dataReq = 1'b0; dataWrite = 1'b0;
    total++; if (dataValid !== 1'b0) $display("FAIL store_valid_c3 got %b want 0", dataValid); else passed++;
    tick();
  endtask

  task automatic test_flush();
    fetchReq = 1'b1; fetchAddress = 16'h0040; tb_rdata = 24'h777777;
    tick(); tick();
    fetchFlush = 1'b1;
    tick();
    fetchFlush = 1'b0; fetchReq = 1'b0;
    tick();
    total++; if ({fetchValid, fetchInstruction} !== {1'b0, 24'h654321}) $display("FAIL flush_suppress_c4 got %h want %h", {fetchValid, fetchInstruction}, {1'b0, 24'h654321}); else passed++;
    tick();
    dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 16'h0050; dataWriteData = 16'h5555;
    total++; if (fetchValid !== 1'b0) $display("FAIL flush_valid_c5 got %b want 0", fetchValid); else passed++;
    tick();
    total++; if ({memReq, memAddress} !== {1'b1, 16'h0050}) $display("FAIL flush_idle_by_c5 got %h want %h", {memReq, memAddress}, {1'b1, 16'h0050}); else passed++;
    tick();
    total++; if (dataValid !== 1'b1) $display("FAIL flush_next_store_valid got %b want 1", dataValid); else passed++;
    tick();
    dataReq = 1'b0; dataWrite = 1'b0;
    tick();
  endtask

  task automatic test_flush_idle();
    fetchReq = 1'b1; fetchFlush = 1'b1; fetchAddress = 16'h0044; tb_rdata = 24'h0F0F0F;
    tick();
    fetchFlush = 1'b0;
    tick(); tick(); tick();
    total++; if ({fetchValid, fetchInstruction} !== {1'b1, 24'h0F0F0F}) $display("FAIL flush_idle_noeffect got %h want %h", {fetchValid, fetchInstruction}, {1'b1, 24'h0F0F0F}); else passed++;
    tick();
    fetchReq = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [WIDTH-1:0] exp_addr;
    int c;
    fetchReq = 1'b1; fetchAddress = 16'h0060;
    dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 16'h0070; tb_rdata = 24'h0A0B0C;
    for (int g = 0; g < 4; g++) begin
      c = 0;
      while (memReq !== 1'b1 && c < 20) begin
        tick();
        c++;
      end
`ifdef ARB_STARVE_GUARD_EN
      exp_addr = (g == 3) ? 16'h0060 : 16'h0070;
`else
      exp_addr = 16'h0070;
`endif
      total++; if (memReq !== 1'b1) $display("FAIL starve_grant%0d_timeout got memReq=%b want 1", g, memReq); else passed++;
      total++; if (memAddress !== exp_addr) $display("FAIL starve_grant%0d_owner got addr %h want %h", g, memAddress, exp_addr); else passed++;
      tick();
    end
    fetchReq = 1'b0; dataReq = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset_midop();
    fetchReq = 1'b1; fetchAddress = 16'h0080; tb_rdata = 24'h222222;
    tick(); tick();
    reset = 1'b1; fetchReq = 1'b0;
    tick();
    total++; if ({memReq, memWrite, memAddress, memWriteData} !== 34'h0) $display("FAIL midreset_mem_c3 got %h want 0", {memReq, memWrite, memAddress, memWriteData}); else passed++;
    total++; if ({fetchValid, dataValid, fetchInstruction, dataReadData} !== 42'h0) $display("FAIL midreset_out_c3 got %h want 0", {fetchValid, dataValid, fetchInstruction, dataReadData}); else passed++;
    reset = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      tick();
      total++; if ({fetchValid, dataValid} !== 2'b00) $display("FAIL midreset_novalid_c%0d got %b want 00", c, {fetchValid, dataValid}); else passed++;
    end
    dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 16'h0090; dataWriteData = 16'h9999;
    tick();
    total++; if ({memReq, memWrite, memAddress} !== {2'b11, 16'h0090}) $display("FAIL midreset_newreq got %h want %h", {memReq, memWrite, memAddress}, {2'b11, 16'h0090}); else passed++;
    tick();
    total++; if (dataValid !== 1'b1) $display("FAIL midreset_newvalid got %b want 1", dataValid); else passed++;
    tick();
    dataReq = 1'b0; dataWrite = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fetchReq = 1'b0; fetchAddress = '0; fetchFlush = 1'b0;
    dataReq = 1'b0; dataWrite = 1'b0; dataAddress = '0; dataWriteData = '0;
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_store();
    test_flush();
    test_flush_idle();
    test_starvation();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
